// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer: replays a table of (dev_id, reg_id, data) writes through an i2c byte-write master with gap and timeout control
module i2c_config_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 100,
  parameter int TIMEOUT    = 4095
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [23:0]       cfg_wdata,
  input  logic [ADDR_W:0]   cfg_count,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] index,
  output logic              m_start,
  output logic [7:0]        m_dev_id,
  output logic [7:0]        m_reg_id,
  output logic [7:0]        m_data,
  input  logic              m_ready
);
  localparam int CMAX = TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int AW1 = ADDR_W + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH = AW1'(2 ** ADDR_W);
  typedef enum logic [2:0] {IDLE, WAIT_RDY, ISSUE, WAIT_ACC, WAIT_DONE, GAP, DONE} state_t;
  state_t r_state, w_next;
  logic [23:0] r_tab [2**ADDR_W];
  logic [ADDR_W:0] r_count;
  logic [CW-1:0] r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic [7:0] r_dev, r_reg, r_data;
  logic r_done, r_err, r_start;
  logic w_go, w_wait, w_tmo, w_gap_end, w_last, w_abort;
  assign w_go = r_state == IDLE && go;
  assign w_wait = r_state inside {WAIT_RDY, WAIT_ACC, WAIT_DONE};
  assign w_tmo = r_cnt == TO_LAST;
  assign w_gap_end = r_cnt == '0;
  assign w_last = AW1'(r_idx) + AW1'(1) == r_count;
  assign w_abort = w_wait && w_next == IDLE;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = go ? (cfg_count == '0 ? DONE : WAIT_RDY) : IDLE;
      WAIT_RDY:  w_next = m_ready ? ISSUE : w_tmo ? IDLE : WAIT_RDY;
      ISSUE:     w_next = WAIT_ACC;
      WAIT_ACC:  w_next = !m_ready ? WAIT_DONE : w_tmo ? IDLE : WAIT_ACC;
      WAIT_DONE: w_next = m_ready ? GAP : w_tmo ? IDLE : WAIT_DONE;
      GAP:       w_next = !w_gap_end ? GAP : w_last ? DONE : WAIT_RDY;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_comb busy = r_state != IDLE;
  always_ff @(posedge clk)
    if (r_state == IDLE && cfg_we) r_tab[cfg_addr] <= cfg_wdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_idx   <= '0;
      r_dev   <= '0;
      r_reg   <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_cnt   <= '0;
    end else begin
      r_done  <= r_state == DONE;
      r_start <= w_next == WAIT_ACC;
      r_err   <= w_go ? 1'b0 : (w_abort | r_err);
      r_idx   <= w_go ? '0 : (r_state == GAP && w_gap_end && !w_last) ? r_idx + ADDR_W'(1) : r_idx;
      r_count <= !w_go ? r_count : cfg_count > DEPTH ? DEPTH : cfg_count;
      if (r_state == ISSUE) {r_dev, r_reg, r_data} <= r_tab[r_idx];
      r_cnt   <= w_next != r_state ? (w_next == GAP ? GAP_LAST : '0) :
                 r_state == GAP ? r_cnt - CW'(1) : w_wait ? r_cnt + CW'(1) : r_cnt;
    end
  end
  assign done = r_done;
  assign error = r_err;
  assign index = r_idx;
  assign m_start = r_start;
  assign m_dev_id = r_dev;
  assign m_reg_id = r_reg;
  assign m_data = r_data;
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// tb_i2c_config_sequencer: randomized check of i2c_config_sequencer against a table/transaction model
module tb_i2c_config_sequencer;
  localparam int AW = 4, GAP = 20, TMO = 50, DEPTH = 16;
  logic clk = 0, reset = 1, cfg_we = 0, go = 0, m_ready;
  logic [AW-1:0] cfg_addr = '0;
  logic [23:0] cfg_wdata = '0;
  logic [AW:0] cfg_count = '0;
  logic busy, done, error, m_start;
  logic [AW-1:0] index;
  logic [7:0] m_dev_id, m_reg_id, m_data;
  int n_chk, n_err, cyc, n_done, done_base, drop_cyc;
  bit hang;
  logic [23:0] ref_tab [DEPTH];
  logic [23:0] op_q[$];
  int idx_q[$], st_q[$], rise_q[$];
  i2c_config_sequencer #(.ADDR_W(AW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_count(cfg_count), .go(go), .busy(busy), .done(done), .error(error), .index(index),
    .m_start(m_start), .m_dev_id(m_dev_id), .m_reg_id(m_reg_id), .m_data(m_data), .m_ready(m_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) n_done <= n_done + 1;
  initial begin
    m_ready = 1;
    forever begin
      @(negedge clk);
      if (m_start && m_ready) begin
        op_q.push_back({m_dev_id, m_reg_id, m_data});
        idx_q.push_back(int'(index));
        st_q.push_back(cyc);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        m_ready = 0;
        drop_cyc = cyc;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        while (hang) @(negedge clk);
        m_ready = 1;
        rise_q.push_back(cyc);
      end
    end
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic write_tab(int a, logic [23:0] d);
    @(negedge clk);
    cfg_we = 1;
    cfg_addr = a[AW-1:0];
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 0;
    ref_tab[a] = d;
  endtask
  task automatic begin_run(int c);
    int n = 0;
    while (!m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rdy_idle", m_ready, 1);
    @(negedge clk);
    op_q.delete();
    idx_q.delete();
    st_q.delete();
    rise_q.delete();
    done_base = n_done;
    cfg_count = c[AW:0];
    go = 1;
    @(negedge clk);
    go = 0;
    check("busy_go", busy, 1);
  endtask
  task automatic finish_run(int exp_n);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("busy_end", busy, 0);
    check("done_cnt", n_done - done_base, 1);
    check("err_end", error, 0);
    check("n_txn", op_q.size(), exp_n);
    for (int k = 0; k < exp_n && k < op_q.size(); k++) begin
      check("op", op_q[k], ref_tab[k]);
      check("idx", idx_q[k], k);
      if (k > 0) check("gap", st_q[k] - rise_q[k-1], GAP + 3);
    end
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", error, 0);
    check("rst_idx", index, 0);
    check("rst_start", m_start, 0);
    check("rst_ops", {m_dev_id, m_reg_id, m_data}, 0);
    reset = 0;
    write_tab(0, 24'h5010AA);
    write_tab(1, 24'h5011BB);
    write_tab(2, 24'h680001);
    begin_run(3);
    finish_run(3);
    op_q.delete();
    @(negedge clk);
    done_base = n_done;
    cfg_count = 0;
    go = 1;
    @(negedge clk);
    go = 0;
    check("z_busy1", busy, 1);
    check("z_done1", done, 0);
    @(negedge clk);
    check("z_busy2", busy, 0);
    check("z_done2", done, 1);
    @(negedge clk);
    check("z_done3", done, 0);
    check("z_ndone", n_done - done_base, 1);
    check("z_nstart", op_q.size(), 0);
    for (int a = 0; a < DEPTH; a++) write_tab(a, 24'($urandom));
    begin_run(16);
    finish_run(16);
    begin_run(20);
    finish_run(16);
    repeat (3) begin
      int c = $urandom_range(1, 15);
      begin_run(c);
      finish_run(c);
    end
    hang = 1;
    begin_run(2);
    n = 0;
    while (!error && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("tmo_time", cyc - drop_cyc, TMO + 1);
    check("tmo_busy", busy, 0);
    check("tmo_start", m_start, 0);
    check("tmo_ntx", op_q.size(), 1);
    @(negedge clk);
    check("tmo_nodone", n_done - done_base, 0);
    check("tmo_sticky", error, 1);
    hang = 0;
    begin_run(2);
    check("err_clr", error, 0);
    finish_run(2);
    begin_run(2);
    n = 0;
    while (op_q.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    cfg_we = 1;
    cfg_addr = 1;
    cfg_wdata = 24'hFFFFFF;
    cfg_count = 5;
    go = 1;
    @(negedge clk);
    cfg_we = 0;
    go = 0;
    finish_run(2);
    repeat (30) @(negedge clk);
    check("norestart_busy", busy, 0);
    check("norestart_ntx", op_q.size(), 2);
    write_tab(1, 24'hFFFFFF);
    begin_run(2);
    finish_run(2);
    hang = 1;
    begin_run(3);
    n = 0;
    while (m_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst2_busy", busy, 0);
    check("rst2_done", done, 0);
    check("rst2_err", error, 0);
    check("rst2_idx", index, 0);
    check("rst2_start", m_start, 0);
    check("rst2_ops", {m_dev_id, m_reg_id, m_data}, 0);
    hang = 0;
    repeat (10) @(negedge clk);
    check("rst2_nodone", n_done - done_base, 0);
    check("rst2_idle", busy, 0);
    begin_run(3);
    finish_run(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
